// File: rtl/instr_encoder.sv
// Inverse of the opcode control decoder: maps a control bundle back to its
// opcode, packs a 32-bit instruction and streams it into instruction memory.
module instr_encoder #(
   parameter int DEPTH     = 256,
   parameter int ADDR_W    = 8,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [4:0]        in_ctrl,
   input  logic [3:0]        in_aluctl,
   input  logic              in_alt,
   input  logic [3:0]        in_rd,
   input  logic [3:0]        in_rs1,
   input  logic [3:0]        in_rs2,
   input  logic [14:0]       in_imm,
   input  logic              last,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic [ADDR_W:0]   count,
   output logic              busy,
   output logic              done,
   output logic              err
);

   typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} state_t;

   localparam logic [1:0] F_R = 2'd0;
   localparam logic [1:0] F_I = 2'd1;
   localparam logic [1:0] F_S = 2'd2;
   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

   state_t            state_q, state_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;

   logic [4:0]  op;
   logic [1:0]  fmt;
   logic        legal;
   logic        accept;
   logic        overflow;
   logic [31:0] word;

   always_comb begin
      op    = 5'b00000;
      fmt   = F_R;
      legal = 1'b1;
      unique case ({in_ctrl, in_aluctl})
         9'b10000_0011: op = 5'b00111;
         9'b10000_0000: op = 5'b00001;
         9'b10000_0100: op = 5'b00010;
         9'b10000_0001: op = 5'b00011;
         9'b10000_0010: op = 5'b00100;
         9'b10000_0101: op = 5'b00101;
         9'b00100_0000: begin
            op  = in_alt ? 5'b01001 : 5'b01000;
            fmt = F_S;
         end
         9'b11000_0000: begin op = 5'b10000; fmt = F_I; end
         9'b11000_1000: begin op = 5'b10001; fmt = F_I; end
         9'b11000_1001: begin op = 5'b10010; fmt = F_I; end
         9'b01010_0000: begin op = 5'b10011; fmt = F_S; end
         9'b11001_0000: begin
            op  = in_alt ? 5'b10100 : 5'b10101;
            fmt = F_I;
         end
         default: legal = 1'b0;
      endcase
   end

   always_comb begin
      word = {op, in_rd, in_rs1, in_rs2, 15'd0};
      if (fmt == F_I) word = {op, in_rd, in_rs1, 4'd0, in_imm};
      if (fmt == F_S) word = {op, 4'd0, in_rs1, in_rs2, in_imm};
   end

   assign accept   = in_valid && in_ready;
   assign overflow = (state_q == RUN) && in_valid && (count_q == DEPTH_C);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         count_q <= '0;
         we_q    <= 1'b0;
         addr_q  <= ADDR_W'(BASE_ADDR);
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   // Error paths take priority over last so a bad final bundle never reports done.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (start) state_d = RUN;
         RUN: begin
            if (overflow || (accept && !legal)) state_d = ERR;
            else if (accept && last)            state_d = DONE;
         end
         DONE, ERR: if (start) state_d = RUN;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      count_d = count_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      if (state_q != RUN && start) count_d = '0;
      if (accept && legal) begin
         we_d    = 1'b1;
         addr_d  = ADDR_W'(BASE_ADDR) + count_q[ADDR_W-1:0];
         wdata_d = word;
         count_d = count_q + 1'b1;
      end
   end

   always_comb begin
      in_ready = (state_q == RUN) && (count_q < DEPTH_C);
      busy     = (state_q == RUN);
      done     = (state_q == DONE);
      err      = (state_q == ERR);
   end

   assign imem_we    = we_q;
   assign imem_addr  = addr_q;
   assign imem_wdata = wdata_q;
   assign count      = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Random and directed stimulus against a table-driven reference of the
// encoder's opcode map, packing rules and run/done/error behaviour.
module tb_instr_encoder;
   localparam int DEPTH  = 8;
   localparam int ADDR_W = 4;
   localparam int BASE   = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [4:0]        in_ctrl = '0;
   logic [3:0]        in_aluctl = '0;
   logic              in_alt = 1'b0;
   logic [3:0]        in_rd = '0;
   logic [3:0]        in_rs1 = '0;
   logic [3:0]        in_rs2 = '0;
   logic [14:0]       in_imm = '0;
   logic              last = 1'b0;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic [ADDR_W:0]   count;
   logic              busy;
   logic              done;
   logic              err;

   instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_ctrl(in_ctrl), .in_aluctl(in_aluctl), .in_alt(in_alt),
      .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
      .last(last), .imem_we(imem_we), .imem_addr(imem_addr),
      .imem_wdata(imem_wdata), .count(count),
      .busy(busy), .done(done), .err(err)
   );

   // fmt: 0 = reg/reg (no imm), 1 = reg/imm (no rs2), 2 = branch/store (no rd)
   typedef struct {
      logic [4:0] ctrl;
      logic [3:0] alu;
      bit         altsens;
      bit         alt;
      logic [4:0] op;
      int         fmt;
   } ent_t;

   ent_t tbl [14];

   int n_chk = 0;
   int n_err = 0;

   bit m_run, m_done, m_err;
   int m_cnt;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit lookup(input logic [4:0] c, input logic [3:0] a,
                                 input bit alt, output logic [4:0] op,
                                 output int fmt);
      op  = '0;
      fmt = 0;
      for (int i = 0; i < 14; i++) begin
         if (tbl[i].ctrl == c && tbl[i].alu == a &&
             (!tbl[i].altsens || tbl[i].alt == alt)) begin
            op  = tbl[i].op;
            fmt = tbl[i].fmt;
            return 1'b1;
         end
      end
      return 1'b0;
   endfunction

   function automatic logic [31:0] pack(input logic [4:0] op, input int fmt,
                                        input logic [3:0] rd,
                                        input logic [3:0] rs1,
                                        input logic [3:0] rs2,
                                        input logic [14:0] imm);
      logic [31:0] w;
      w = {op, 27'd0};
      w[22:19] = rs1;
      if (fmt != 2) w[26:23] = rd;
      if (fmt != 1) w[18:15] = rs2;
      if (fmt != 0) w[14:0]  = imm;
      return w;
   endfunction

   task automatic cyc(input bit st, input bit v, input logic [4:0] c,
                      input logic [3:0] a, input bit alt,
                      input logic [3:0] rd, input logic [3:0] rs1,
                      input logic [3:0] rs2, input logic [14:0] imm,
                      input bit lst);
      bit          ok;
      bit          exp_we;
      logic [4:0]  op;
      int          fmt;
      int          exp_addr;
      logic [31:0] exp_data;
      start = st; in_valid = v; in_ctrl = c; in_aluctl = a; in_alt = alt;
      in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; last = lst;
      #1;
      check("in_ready", 32'(in_ready), 32'(m_run && m_cnt < DEPTH));
      ok       = lookup(c, a, alt, op, fmt);
      exp_we   = 1'b0;
      exp_addr = 0;
      exp_data = '0;
      if (m_run) begin
         if (v && m_cnt == DEPTH) begin
            m_run = 0; m_err = 1;
         end else if (v && !ok) begin
            m_run = 0; m_err = 1;
         end else if (v) begin
            exp_we   = 1'b1;
            exp_addr = BASE + m_cnt;
            exp_data = pack(op, fmt, rd, rs1, rs2, imm);
            m_cnt++;
            if (lst) begin m_run = 0; m_done = 1; end
         end
      end else if (st) begin
         m_run = 1; m_done = 0; m_err = 0; m_cnt = 0;
      end
      @(posedge clk);
      #1;
      check("imem_we", 32'(imem_we), 32'(exp_we));
      if (exp_we) begin
         check("imem_addr", 32'(imem_addr), 32'(exp_addr));
         check("imem_wdata", imem_wdata, exp_data);
      end
      check("count", 32'(count), 32'(m_cnt));
      check("busy", 32'(busy), 32'(m_run));
      check("done", 32'(done), 32'(m_done));
      check("err", 32'(err), 32'(m_err));
      start = 1'b0;
      in_valid = 1'b0;
      last = 1'b0;
   endtask

   task automatic issue(input int k, input bit alt, input logic [3:0] rd,
                        input logic [3:0] rs1, input logic [3:0] rs2,
                        input logic [14:0] imm, input bit lst);
      cyc(0, 1, tbl[k].ctrl, tbl[k].alu, alt, rd, rs1, rs2, imm, lst);
   endtask

   task automatic do_start();
      cyc(1, 0, '0, '0, 0, '0, '0, '0, '0, 0);
   endtask

   task automatic do_idle();
      cyc(0, 0, '0, '0, 0, '0, '0, '0, '0, 0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      start = 1'b0;
      @(posedge clk);
      #1;
      m_run = 0; m_done = 0; m_err = 0; m_cnt = 0;
      check("rst_we", 32'(imem_we), 32'd0);
      check("rst_addr", 32'(imem_addr), 32'(BASE));
      check("rst_wdata", imem_wdata, 32'd0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_ready", 32'(in_ready), 32'd0);
      rst_n = 1'b1;
      in_valid = 1'b0;
   endtask

   initial begin
      tbl = '{
         '{5'b10000, 4'b0011, 0, 0, 5'b00111, 0},
         '{5'b10000, 4'b0000, 0, 0, 5'b00001, 0},
         '{5'b10000, 4'b0100, 0, 0, 5'b00010, 0},
         '{5'b10000, 4'b0001, 0, 0, 5'b00011, 0},
         '{5'b10000, 4'b0010, 0, 0, 5'b00100, 0},
         '{5'b10000, 4'b0101, 0, 0, 5'b00101, 0},
         '{5'b00100, 4'b0000, 1, 0, 5'b01000, 2},
         '{5'b00100, 4'b0000, 1, 1, 5'b01001, 2},
         '{5'b11000, 4'b0000, 0, 0, 5'b10000, 1},
         '{5'b11000, 4'b1000, 0, 0, 5'b10001, 1},
         '{5'b11000, 4'b1001, 0, 0, 5'b10010, 1},
         '{5'b01010, 4'b0000, 0, 0, 5'b10011, 2},
         '{5'b11001, 4'b0000, 1, 1, 5'b10100, 1},
         '{5'b11001, 4'b0000, 1, 0, 5'b10101, 1}
      };

      do_reset();
      do_idle();
      do_start();

      issue(1, 0, 4'd3, 4'd1, 4'd2, 15'h1234, 0);
      check("add_word", imem_wdata, 32'h0989_0000);
      issue(6, 0, 4'd7, 4'd4, 4'd5, 15'h0010, 0);
      check("beq_op", 32'(imem_wdata[31:27]), 32'b01000);
      issue(7, 1, 4'd7, 4'd4, 4'd5, 15'h0010, 0);
      check("bgt_rd", 32'(imem_wdata[26:23]), 32'd0);
      issue(12, 1, 4'd2, 4'd9, 4'd6, 15'h0004, 0);
      check("lb_rs2", 32'(imem_wdata[18:15]), 32'd0);
      issue(13, 0, 4'd2, 4'd9, 4'd6, 15'h0008, 1);
      check("lw_op", 32'(imem_wdata[31:27]), 32'b10101);
      do_idle();

      do_start();
      cyc(0, 1, 5'b10000, 4'b0110, 0, 4'd1, 4'd1, 4'd1, '0, 1);
      do_idle();
      do_start();
      check("restart_err", 32'(err), 32'd0);

      for (int i = 0; i < DEPTH; i++)
         issue(i % 14, 1'(i), 4'(i), 4'(i + 1), 4'(i + 2), 15'(i * 7), 0);
      issue(0, 0, 4'd1, 4'd1, 4'd1, '0, 0);
      check("ovf_count", 32'(count), 32'(DEPTH));
      do_start();

      issue(8, 0, 4'd5, 4'd6, 4'd7, 15'h7fff, 0);
      in_valid = 1'b1;
      in_ctrl = tbl[1].ctrl;
      in_aluctl = tbl[1].alu;
      do_reset();
      do_idle();

      for (int i = 0; i < 14; i++) begin
         if (i == 0) do_start();
         issue(i, tbl[i].alt, 4'($urandom), 4'($urandom), 4'($urandom),
               15'($urandom), 0);
         if (i == DEPTH - 1) do_start();
         if (m_cnt == DEPTH) begin
            do_idle();
         end
      end
      do_reset();

      for (int n = 0; n < 600; n++) begin
         int         k;
         bit         st, v, lst;
         logic [4:0] c;
         logic [3:0] a;
         k   = int'($urandom_range(0, 13));
         c   = tbl[k].ctrl;
         a   = tbl[k].alu;
         if ($urandom_range(0, 9) == 0) begin
            c = 5'($urandom);
            a = 4'($urandom);
         end
         st  = ($urandom_range(0, 3) == 0);
         v   = ($urandom_range(0, 3) != 0);
         lst = ($urandom_range(0, 11) == 0);
         if ($urandom_range(0, 149) == 0) do_reset();
         else cyc(st, v, c, a, 1'($urandom), 4'($urandom), 4'($urandom),
                  4'($urandom), 15'($urandom), lst);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
